// File: rtl/spi_bridge_slave.sv
// Mode-0 SPI slave bridge oversampled in the clk domain: rx/tx word FIFOs,
// tag-zero status words, saturating error counters and a post-reset idle lockout.
module spi_bridge_slave #(
  parameter int DATA_W      = 32,
  parameter int TAG_W       = 4,
  parameter int STAT_W      = 25,
  parameter int DEPTH_LOG2  = 4,
  parameter int SYNC_STAGES = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              spi_clk,
  input  logic              spi_mosi,
  output logic              spi_miso,
  input  logic              spi_cs,
  output logic              gpio_not_empty,
  output logic              gpio_not_full,
  input  logic              wr_en,
  input  logic [DATA_W-1:0] wr_din,
  output logic              wr_full,
  input  logic              rd_en,
  output logic              rd_rdy,
  output logic [DATA_W-1:0] rd_dout,
  output logic [7:0]        err_frame,
  output logic [7:0]        err_ovf,
  output logic [7:0]        err_drop
);

  localparam int DEPTH  = 1 << DEPTH_LOG2;
  localparam int CNT_W  = DEPTH_LOG2 + 1;
  localparam int BIT_W  = $clog2(DATA_W + 2);
  localparam int LOCK_W = $clog2(SYNC_STAGES + 2);
  localparam logic [BIT_W-1:0]  BIT_MAX   = BIT_W'(DATA_W + 1);
  localparam logic [BIT_W-1:0]  BIT_FULL  = BIT_W'(DATA_W);
  localparam logic [LOCK_W-1:0] LOCK_DONE = LOCK_W'(SYNC_STAGES + 1);
  localparam logic [CNT_W-1:0]  CNT_FULL  = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0]  CNT_ZERO  = {CNT_W{1'b0}};

  typedef enum logic [1:0] {
    WAIT_IDLE = 2'd0,
    IDLE      = 2'd1,
    ACTIVE    = 2'd2
  } state_t;

  function automatic logic [7:0] sat_inc(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  function automatic logic tag_is_zero(input logic [DATA_W-1:0] w);
    return (w[DATA_W-1 -: TAG_W] == {TAG_W{1'b0}});
  endfunction

  state_t state_q, state_d;
  logic [SYNC_STAGES-1:0] cs_sync_q, cs_sync_d;
  logic [SYNC_STAGES-1:0] sclk_sync_q, sclk_sync_d;
  logic [SYNC_STAGES-1:0] mosi_sync_q, mosi_sync_d;
  logic cs_prev_q, cs_prev_d;
  logic sclk_prev_q, sclk_prev_d;
  logic [LOCK_W-1:0] lock_cnt_q, lock_cnt_d;
  logic [DATA_W-1:0] rx_shift_q, rx_shift_d;
  logic [DATA_W-1:0] tx_shift_q, tx_shift_d;
  logic [BIT_W-1:0]  bitcnt_q, bitcnt_d;
  logic [STAT_W-1:0] status_q, status_d;
  logic [DEPTH_LOG2-1:0] rx_wr_ptr_q, rx_wr_ptr_d, rx_rd_ptr_q, rx_rd_ptr_d;
  logic [DEPTH_LOG2-1:0] tx_wr_ptr_q, tx_wr_ptr_d, tx_rd_ptr_q, tx_rd_ptr_d;
  logic [CNT_W-1:0] rx_cnt_q, rx_cnt_d, tx_cnt_q, tx_cnt_d;
  logic [7:0] err_frame_q, err_frame_d, err_ovf_q, err_ovf_d, err_drop_q, err_drop_d;
  logic miso_q, miso_d;
  logic rd_rdy_q, rd_rdy_d, not_full_q, not_full_d;
  logic not_empty_q, not_empty_d, wr_full_q, wr_full_d;
  logic [DATA_W-1:0] rx_mem_q [DEPTH];
  logic [DATA_W-1:0] tx_mem_q [DEPTH];

  logic cs_s, sclk_s, mosi_s;
  logic cs_fall_s, cs_rise_s, sclk_rise_s, sclk_fall_s;
  logic rx_push_s, rx_pop_s, tx_push_s, tx_pop_s;
  logic [DATA_W-1:0] idle_word_s, tx_head_s;

  assign cs_s   = cs_sync_q[SYNC_STAGES-1];
  assign sclk_s = sclk_sync_q[SYNC_STAGES-1];
  assign mosi_s = mosi_sync_q[SYNC_STAGES-1];

  // Next-state logic: input conditioning, frame FSM, FIFO bookkeeping and counters
  always_comb begin
    state_d     = state_q;
    cs_sync_d   = {cs_sync_q[SYNC_STAGES-2:0], spi_cs};
    sclk_sync_d = {sclk_sync_q[SYNC_STAGES-2:0], spi_clk};
    mosi_sync_d = {mosi_sync_q[SYNC_STAGES-2:0], spi_mosi};
    cs_prev_d   = cs_s;
    sclk_prev_d = sclk_s;
    cs_fall_s   = cs_prev_q & ~cs_s;
    cs_rise_s   = ~cs_prev_q & cs_s;
    sclk_rise_s = ~sclk_prev_q & sclk_s;
    sclk_fall_s = sclk_prev_q & ~sclk_s;
    rx_shift_d  = rx_shift_q;
    tx_shift_d  = tx_shift_q;
    bitcnt_d    = bitcnt_q;
    status_d    = status_q;
    err_frame_d = err_frame_q;
    err_ovf_d   = err_ovf_q;
    err_drop_d  = err_drop_q;
    rx_push_s   = 1'b0;
    tx_pop_s    = 1'b0;
    tx_head_s   = tx_mem_q[tx_rd_ptr_q];
    idle_word_s = {DATA_W{1'b0}};
    idle_word_s[STAT_W] = 1'b1;
    idle_word_s[STAT_W-1:0] = status_q;

    // Lockout keeps a frame already in progress at reset from being decoded
    if (lock_cnt_q != LOCK_DONE) begin
      lock_cnt_d = lock_cnt_q + LOCK_W'(1);
    end else begin
      lock_cnt_d = lock_cnt_q;
    end

    rx_pop_s  = rd_en && (rx_cnt_q != CNT_ZERO);
    tx_push_s = wr_en && (tx_cnt_q != CNT_FULL);
    if (wr_en && !tx_push_s) begin
      err_drop_d = sat_inc(err_drop_q);
    end else begin
      err_drop_d = err_drop_q;
    end

    case (state_q)
      WAIT_IDLE: begin
        if ((lock_cnt_q == LOCK_DONE) && cs_s) begin
          state_d = IDLE;
        end else begin
          state_d = WAIT_IDLE;
        end
      end
      IDLE: begin
        if (cs_fall_s) begin
          state_d    = ACTIVE;
          bitcnt_d   = {BIT_W{1'b0}};
          rx_shift_d = {DATA_W{1'b0}};
          if (tx_cnt_q != CNT_ZERO) begin
            tx_pop_s   = 1'b1;
            tx_shift_d = tx_head_s;
            if (tag_is_zero(tx_head_s)) begin
              status_d = tx_head_s[STAT_W-1:0];
            end else begin
              status_d = status_q;
            end
          end else begin
            tx_shift_d = idle_word_s;
          end
        end else begin
          state_d = IDLE;
        end
      end
      ACTIVE: begin
        if (cs_rise_s) begin
          state_d = IDLE;
          if (bitcnt_q != BIT_FULL) begin
            err_frame_d = sat_inc(err_frame_q);
          end else if (tag_is_zero(rx_shift_q)) begin
            rx_push_s = 1'b0;
          end else if (rx_cnt_q == CNT_FULL) begin
            err_ovf_d = sat_inc(err_ovf_q);
          end else begin
            rx_push_s = 1'b1;
          end
        end else begin
          state_d = ACTIVE;
          if (sclk_rise_s) begin
            rx_shift_d = {rx_shift_q[DATA_W-2:0], mosi_s};
            bitcnt_d   = (bitcnt_q == BIT_MAX) ? bitcnt_q : bitcnt_q + BIT_W'(1);
          end else if (sclk_fall_s) begin
            tx_shift_d = {tx_shift_q[DATA_W-2:0], 1'b0};
          end else begin
            bitcnt_d = bitcnt_q;
          end
        end
      end
      default: begin
        state_d = WAIT_IDLE;
      end
    endcase

    rx_wr_ptr_d = rx_push_s ? rx_wr_ptr_q + DEPTH_LOG2'(1) : rx_wr_ptr_q;
    rx_rd_ptr_d = rx_pop_s  ? rx_rd_ptr_q + DEPTH_LOG2'(1) : rx_rd_ptr_q;
    tx_wr_ptr_d = tx_push_s ? tx_wr_ptr_q + DEPTH_LOG2'(1) : tx_wr_ptr_q;
    tx_rd_ptr_d = tx_pop_s  ? tx_rd_ptr_q + DEPTH_LOG2'(1) : tx_rd_ptr_q;
    rx_cnt_d = rx_cnt_q + CNT_W'(rx_push_s) - CNT_W'(rx_pop_s);
    tx_cnt_d = tx_cnt_q + CNT_W'(tx_push_s) - CNT_W'(tx_pop_s);

    miso_d      = (state_d == ACTIVE) ? tx_shift_d[DATA_W-1] : 1'b0;
    rd_rdy_d    = (rx_cnt_d != CNT_ZERO);
    not_full_d  = (rx_cnt_d != CNT_FULL);
    not_empty_d = (tx_cnt_d != CNT_ZERO);
    wr_full_d   = (tx_cnt_d == CNT_FULL);
  end

  // State and flag registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= WAIT_IDLE;
      cs_sync_q   <= {SYNC_STAGES{1'b1}};
      sclk_sync_q <= {SYNC_STAGES{1'b0}};
      mosi_sync_q <= {SYNC_STAGES{1'b0}};
      cs_prev_q   <= 1'b1;
      sclk_prev_q <= 1'b0;
      lock_cnt_q  <= {LOCK_W{1'b0}};
      rx_shift_q  <= {DATA_W{1'b0}};
      tx_shift_q  <= {DATA_W{1'b0}};
      bitcnt_q    <= {BIT_W{1'b0}};
      status_q    <= {STAT_W{1'b0}};
      rx_wr_ptr_q <= {DEPTH_LOG2{1'b0}};
      rx_rd_ptr_q <= {DEPTH_LOG2{1'b0}};
      tx_wr_ptr_q <= {DEPTH_LOG2{1'b0}};
      tx_rd_ptr_q <= {DEPTH_LOG2{1'b0}};
      rx_cnt_q    <= CNT_ZERO;
      tx_cnt_q    <= CNT_ZERO;
      err_frame_q <= 8'd0;
      err_ovf_q   <= 8'd0;
      err_drop_q  <= 8'd0;
      miso_q      <= 1'b0;
      rd_rdy_q    <= 1'b0;
      not_full_q  <= 1'b1;
      not_empty_q <= 1'b0;
      wr_full_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cs_sync_q   <= cs_sync_d;
      sclk_sync_q <= sclk_sync_d;
      mosi_sync_q <= mosi_sync_d;
      cs_prev_q   <= cs_prev_d;
      sclk_prev_q <= sclk_prev_d;
      lock_cnt_q  <= lock_cnt_d;
      rx_shift_q  <= rx_shift_d;
      tx_shift_q  <= tx_shift_d;
      bitcnt_q    <= bitcnt_d;
      status_q    <= status_d;
      rx_wr_ptr_q <= rx_wr_ptr_d;
      rx_rd_ptr_q <= rx_rd_ptr_d;
      tx_wr_ptr_q <= tx_wr_ptr_d;
      tx_rd_ptr_q <= tx_rd_ptr_d;
      rx_cnt_q    <= rx_cnt_d;
      tx_cnt_q    <= tx_cnt_d;
      err_frame_q <= err_frame_d;
      err_ovf_q   <= err_ovf_d;
      err_drop_q  <= err_drop_d;
      miso_q      <= miso_d;
      rd_rdy_q    <= rd_rdy_d;
      not_full_q  <= not_full_d;
      not_empty_q <= not_empty_d;
      wr_full_q   <= wr_full_d;
    end
  end

  // FIFO storage; pointers alone define contents, so no reset is needed
  always_ff @(posedge clk) begin
    if (rx_push_s) begin
      rx_mem_q[rx_wr_ptr_q] <= rx_shift_q;
    end
    if (tx_push_s) begin
      tx_mem_q[tx_wr_ptr_q] <= wr_din;
    end
  end

  assign spi_miso       = miso_q;
  assign rd_rdy         = rd_rdy_q;
  assign rd_dout        = rx_mem_q[rx_rd_ptr_q];
  assign gpio_not_full  = not_full_q;
  assign gpio_not_empty = not_empty_q;
  assign wr_full        = wr_full_q;
  assign err_frame      = err_frame_q;
  assign err_ovf        = err_ovf_q;
  assign err_drop       = err_drop_q;

endmodule

// File: doc/spi_bridge_slave.md
Name: spi_bridge_slave

Overview:
- Parametrised successor to the Jetson SPI bridge. Single-clock SPI slave: spi_clk, spi_mosi and spi_cs are oversampled in the clk domain, so there is no second clock domain.
- Built-in rx (SPI->core) and tx (core->SPI) FIFOs; tag-zero words act as status/poll words.
- Adds frame-length checking, overflow, drop and error counters, and a post-reset idle lockout.
- Sits between the Jetson SPI pins and the core command/response path.

Parameters:
DATA_W, 32, SPI word width in bits (MSB first)
TAG_W, 4, width of tag field at [DATA_W-1:DATA_W-TAG_W]; tag 0 = status/null word
STAT_W, 25, width of status shadow register; must satisfy STAT_W <= DATA_W-TAG_W-3
DEPTH_LOG2, 4, log2 of depth of each FIFO (DEPTH = 2**DEPTH_LOG2)
SYNC_STAGES, 2, synchroniser flops on each SPI input (min 2)

Ports:
clk  in  1  system clock
rst  in  1  synchronous active-high reset
spi_clk  in  1  SPI clock, mode 0 (CPOL=0, CPHA=0)
spi_mosi  in  1  SPI data in
spi_miso  out  1  SPI data out
spi_cs  in  1  chip select, active low
gpio_not_empty  out  1  tx FIFO non-empty (host attention)
gpio_not_full  out  1  rx FIFO has space
wr_en  in  1  push wr_din into tx FIFO
wr_din  in  DATA_W  core->host word
wr_full  out  1  tx FIFO full
rd_en  in  1  pop rx FIFO head
rd_rdy  out  1  rx FIFO head valid
rd_dout  out  DATA_W  rx FIFO head (first-word fall-through)
err_frame  out  8  saturating count of bad-length frames
err_ovf  out  8  saturating count of rx words dropped because rx FIFO full
err_drop  out  8  saturating count of wr_en dropped because tx FIFO full

Behaviour:
Input conditioning:
- Each SPI input passes through SYNC_STAGES flops, then one edge-detect flop.
- Reset values: cs=1, sclk=0, mosi=0.
- Host constraint: sclk high and low phases >= SYNC_STAGES+2 clk cycles.

State machine:
- WAIT_IDLE (reset state) -> IDLE when synced cs=1.
- IDLE -> ACTIVE on synced cs falling edge.
- ACTIVE -> IDLE on synced cs rising edge.
- sclk edges outside ACTIVE are ignored.

Frame start (IDLE->ACTIVE cycle):
- tx FIFO non-empty: pop head into tx_shift.
- tx FIFO empty: load tx_shift = {TAG 0, zeros, tx_empty=1 at bit STAT_W, status_shadow[STAT_W-1:0]}.
- A popped word whose tag is 0 also copies bits [STAT_W-1:0] into status_shadow in that same cycle.
- bitcnt <= 0; rx_shift <= 0.
- A wr_en in the same cycle into an empty FIFO is not sent in this frame.

Shifting and output:
- sclk rising: rx_shift <= {rx_shift[DATA_W-2:0], mosi}; bitcnt increments, saturating at DATA_W+1.
- sclk falling: tx_shift <= tx_shift << 1.
- spi_miso = tx_shift[DATA_W-1] while ACTIVE, else 0.

Frame end (ACTIVE->IDLE cycle):
- bitcnt != DATA_W: discard the word, err_frame++.
- Else tag == 0: discard silently (poll frame).
- Else rx FIFO full: discard, err_ovf++.
- Else push rx_shift.

rx FIFO:
- rd_rdy = count != 0.
- rd_en while rd_rdy pops; rd_en while empty is ignored.
- Push and pop in the same cycle both occur. Fullness is judged on count before the pop, so full plus pop plus push rejects the push.
- gpio_not_full = count != DEPTH.

tx FIFO:
- wr_en while full is dropped, err_drop++.
- wr_full = count == DEPTH; gpio_not_empty = count != 0.
- Simultaneous wr_en and frame-start pop both occur.

Counters:
- Saturate at 255.
- Cleared only by rst.

Reset:
- All FIFOs empty; shifts, status_shadow and counters 0; spi_miso=0; rd_rdy=0; gpio_not_empty=0; gpio_not_full=1; wr_full=0; state WAIT_IDLE.
- Reset asserted mid-frame abandons the frame.
- If cs is still low after reset, the remainder of that frame is ignored until cs goes high.

Latency:
- An rx word is visible on rd_rdy/rd_dout 1 clk after the frame-end cycle.
- cs edge to frame-start/frame-end action: SYNC_STAGES+1 clk.

Test Plan:
- Host sends 32-bit 0x1234_5678 with tx FIFO empty -> rd_rdy=1 with rd_dout=0x12345678; MISO shifts 0x0200_0000 (tx_empty bit 25 set, status 0).
- Core writes 0x0000_00AB then 0xA000_0001; three host frames of 0x0 -> MISO words 0x000000AB, 0xA0000001, 0x020000AB; no rx push; gpio_not_empty falls after the second frame start.
- Frame of 31 bits and frame of 33 bits -> no push, err_frame=2, rx FIFO unchanged.
- 17 valid tagged frames with no rd_en (DEPTH=16) -> 16 stored, err_ovf=1, gpio_not_full=0; one rd_en -> gpio_not_full=1.
- 17 wr_en with tx FIFO full path -> err_drop=1, wr_full=1.
- Assert rst for 1 clk mid-frame (cs low, 10 bits sent), then finish the frame -> no push, err_frame=0. The next full frame 0x3000_0005 is pushed normally.
